prbs10_checker: RTL
===================

Name: prbs10_checker

Overview:
- Receive-end checker for the team's 10-bit PRBS stream.
- Polynomial x^10 + x^7 + 1: feedback = r[9] ^ r[6], shift left, feedback enters at LSB.
- Self-synchronises to an incoming serial bit stream, verifies every subsequent bit, counts errors, reports lock and loss of lock.
- Sits after any serial link or loopback path that carries generator output; status goes to a debug register block.

Parameters:
- LOCK_CNT, 16: consecutive correct bits in VERIFY needed to declare lock.
- WIN_LEN, 64: length of the error-monitoring window in LOCKED, in valid bits.
- LOSS_THRESH, 4: errors within one window that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clock  in  1  Single clock; all logic on its rising edge.
- reset  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Qualifies in_bit. The stream advances only on cycles where in_valid=1.
- in_bit  in  1  Received serial bit, equal to the generator's feedback bit for that step.
- clear_cnt  in  1  Synchronous clear of err_count and bit_count.
- locked  out  1  High while in LOCKED.
- err_pulse  out  1  One-cycle pulse on each mismatching bit in VERIFY or LOCKED.
- lost_pulse  out  1  One-cycle pulse on the LOCKED->SEED transition.
- err_count  out  ERR_W  Errors counted while LOCKED; saturates at all-ones.
- bit_count  out  32  Valid bits checked while LOCKED; saturates at all-ones.

Behaviour:
- Reset (asynchronous assert):
  - state=SEED, shift reg=0, all counters=0.
  - locked=0, err_pulse=0, lost_pulse=0, err_count=0, bit_count=0.
- Shift reg update: on every valid bit the register shifts in the received bit (reg <= {reg[8:0], in_bit}) in every state.
- Expected bit = reg[9] ^ reg[6], computed from the pre-shift register. mismatch = in_bit != expected.
- SEED:
  - Counts 10 valid bits, then goes to VERIFY.
  - If the register would be all-zero after the 10th bit, the seed count restarts instead (illegal LFSR state).
- VERIFY:
  - A valid matching bit increments good_cnt.
  - A mismatch pulses err_pulse, clears good_cnt and returns to SEED with seed count 0.
  - When good_cnt reaches LOCK_CNT, go to LOCKED. locked=1 from the cycle after the LOCK_CNT-th good bit.
- LOCKED:
  - Each valid bit increments bit_count and win_cnt.
  - A mismatch pulses err_pulse and increments err_count and win_err.
  - When win_cnt reaches WIN_LEN, both win_cnt and win_err clear.
  - If win_err reaches LOSS_THRESH (counting the current bit):
    - go to SEED next cycle; pulse lost_pulse; locked drops in that same cycle.
    - err_count keeps its value; bit_count still counts that bit.
- Outputs:
  - err_pulse and lost_pulse are registered; each is high for exactly the cycle after the offending valid bit.
  - Total latency from an in_bit sample to its status effect is 1 cycle.
- in_valid=0: no state, counter or register change; pulses low.
- clear_cnt with a simultaneous valid error: the clear wins, so err_count=0 that cycle (the error is not counted). err_pulse still fires.
- Saturating counters hold at max and never wrap.
- Window boundary and threshold on the same bit: the loss takes priority.
- Reset mid-stream: immediate return to the reset values; resynchronisation needs 10+LOCK_CNT valid bits.

Decomposition:
- Package prbs10_pkg holds:
  - PRBS_W=10, TAP_HI=9, TAP_LO=6;
  - state enum {SEED, VERIFY, LOCKED};
  - function prbs10_next(reg) returning the feedback bit, shared with the generator and the bench model.
- One natural sub-module: sat_counter (parameterised width; inc and clr inputs; clr dominant), instanced for err_count and bit_count.

Test Plan:
- Clean stream:
  - Stimulus: drive generator-model bits from seed 10'h00F, in_valid=1 continuously.
  - Response: locked rises exactly on the cycle after valid bit 26. After 1000 further bits, err_count=0 and bit_count=1000.
- Gapped valid:
  - Stimulus: same stream with in_valid toggling 1,0,1,0.
  - Response: lock after 26 valid bits (52 cycles). No spurious pulses.
- Single error:
  - Stimulus: after lock, invert 1 bit.
  - Response: err_pulse for 1 cycle; err_count=1; locked stays 1.
- Error burst:
  - Stimulus: after lock, invert 4 bits within 64.
  - Response: lost_pulse on the cycle after the 4th error; locked=0; err_count=4. Lock regained 26 valid clean bits later.
- All-zero input:
  - Stimulus: 100 zero bits.
  - Response: never leaves SEED; locked=0; err_count=0.
- Clear and reset:
  - Stimulus: clear_cnt coincident with an error.
  - Response: err_count=0. Asserting reset mid-LOCKED drops locked asynchronously and zeroes the counters.

Source files
------------

// File: rtl/prbs10_pkg.sv
// Shared definitions for the PRBS-10 (x^10 + x^7 + 1) generator/checker family.
package prbs10_pkg;

   localparam int unsigned PRBS_W = 10;
   localparam int unsigned TAP_HI = 9;
   localparam int unsigned TAP_LO = 6;
   localparam logic [PRBS_W-1:0] TAP_MASK = PRBS_W'((1 << TAP_HI) | (1 << TAP_LO));

   typedef enum logic [1:0] {
      SEED,
      VERIFY,
      LOCKED
   } state_t;

   // Feedback bit for the next step: r[TAP_HI] ^ r[TAP_LO].
   function automatic logic prbs10_next(input logic [PRBS_W-1:0] r);
      return ^(r & TAP_MASK);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/prbs10_checker.sv
// PRBS-10 receive checker: self-seeds from the stream, verifies, locks and
// monitors the error rate per window, dropping lock when it gets too high.
module prbs10_checker
   import prbs10_pkg::*;
#(
   parameter int unsigned LOCK_CNT    = 16,
   parameter int unsigned WIN_LEN     = 64,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned ERR_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic             lost_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      bit_count
);

   localparam int unsigned SEED_W = $clog2(PRBS_W + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);
   localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

   state_t            state;
   logic [PRBS_W-1:0] sreg;
   logic [SEED_W-1:0] seed_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [WERR_W-1:0] win_err;

   logic [PRBS_W-1:0] shifted;
   logic              mismatch;
   logic [WIN_W-1:0]  win_cnt_inc;
   logic [WERR_W-1:0] win_err_inc;
   logic              err_inc;
   logic              bit_inc;

   // Expected bit comes from the pre-shift register; window counters include the current bit.
   always_comb begin
      shifted     = {sreg[PRBS_W-2:0], in_bit};
      mismatch    = in_bit != prbs10_next(sreg);
      win_cnt_inc = win_cnt + WIN_W'(1);
      win_err_inc = win_err + WERR_W'(mismatch);
      bit_inc     = in_valid && (state == LOCKED);
      err_inc     = bit_inc && mismatch;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= SEED;
         sreg       <= '0;
         seed_cnt   <= '0;
         good_cnt   <= '0;
         win_cnt    <= '0;
         win_err    <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         lost_pulse <= 1'b0;
      end else begin
         err_pulse  <= 1'b0;
         lost_pulse <= 1'b0;
         if (in_valid) begin
            sreg <= shifted;
            unique case (state)
               SEED: begin
                  if (seed_cnt == SEED_W'(PRBS_W - 1)) begin
                     seed_cnt <= '0;
                     // An all-zero register is a dead LFSR state; keep seeding.
                     if (shifted != '0) begin
                        state    <= VERIFY;
                        good_cnt <= '0;
                     end
                  end else begin
                     seed_cnt <= seed_cnt + SEED_W'(1);
                  end
               end
               VERIFY: begin
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     good_cnt  <= '0;
                     seed_cnt  <= '0;
                     state     <= SEED;
                  end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else begin
                     good_cnt <= good_cnt + GOOD_W'(1);
                  end
               end
               LOCKED: begin
                  err_pulse <= mismatch;
                  // Loss outranks a window boundary landing on the same bit.
                  if (win_err_inc == WERR_W'(LOSS_THRESH)) begin
                     state      <= SEED;
                     locked     <= 1'b0;
                     lost_pulse <= 1'b1;
                     seed_cnt   <= '0;
                     win_cnt    <= '0;
                     win_err    <= '0;
                  end else if (win_cnt_inc == WIN_W'(WIN_LEN)) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt_inc;
                     win_err <= win_err_inc;
                  end
               end
               default: state <= SEED;
            endcase
         end
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (err_inc),
      .clr   (clear_cnt),
      .count (err_count)
   );

   sat_counter #(.W(32)) u_bit_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (bit_inc),
      .clr   (clear_cnt),
      .count (bit_count)
   );

endmodule
